// File: rtl/param_regfile_2r1w.sv
// Parametrised register file: one write port, two registered read ports sharing a read enable,
// optional write-to-read bypass and optional hard-wired zero register.
module param_regfile_2r1w #(
    parameter int  WIDTH    = 4,
    parameter int  DEPTH    = 8,
    parameter bit  BYPASS   = 1'b1,
    parameter bit  ZERO_REG = 1'b0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             WE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic             RE,
    input  logic [AW-1:0]    RA,
    input  logic [AW-1:0]    RB,
    output logic [WIDTH-1:0] RDoutA,
    output logic [WIDTH-1:0] RDoutB,
    output logic             RValid
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_V);
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    assign wr_ok = WE && in_range(WA) && !is_zero_reg(WA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[WA] <= WD;
        end
    end

    // Priority: out-of-range and zero register read 0, then bypass, then the stored value.
    always_comb begin
        sel_a = '0;
        if (in_range(RA) && !is_zero_reg(RA)) begin
            if (BYPASS && wr_ok && (WA == RA)) begin
                sel_a = WD;
            end else begin
                sel_a = mem[RA];
            end
        end
    end

    always_comb begin
        sel_b = '0;
        if (in_range(RB) && !is_zero_reg(RB)) begin
            if (BYPASS && wr_ok && (WA == RB)) begin
                sel_b = WD;
            end else begin
                sel_b = mem[RB];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RDoutA <= '0;
            RDoutB <= '0;
            RValid <= 1'b0;
        end else begin
            RValid <= RE;
            if (RE) begin
                RDoutA <= sel_a;
                RDoutB <= sel_b;
            end
        end
    end

endmodule

// File: tb/tb_param_regfile_2r1w.sv
// Scoreboard bench for param_regfile_2r1w: four instances (default, no bypass, zero register,
// DEPTH=6) driven with directed vectors; a negedge monitor pops expected read data on RValid.
module tb_param_regfile_2r1w;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       we   [4];
    logic [2:0] wa   [4];
    logic [3:0] wd   [4];
    logic       re   [4];
    logic [2:0] ra   [4];
    logic [2:0] rb   [4];
    logic [3:0] rda  [4];
    logic [3:0] rdb  [4];
    logic       rv   [4];

    exp_t expq [4][$];
    int   vectors;
    int   miscompares;

    param_regfile_2r1w #(.WIDTH(4), .DEPTH(8), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_def (
        .clk(clk), .rst_n(rst_n), .WE(we[0]), .WA(wa[0]), .WD(wd[0]), .RE(re[0]),
        .RA(ra[0]), .RB(rb[0]), .RDoutA(rda[0]), .RDoutB(rdb[0]), .RValid(rv[0]));

    param_regfile_2r1w #(.WIDTH(4), .DEPTH(8), .BYPASS(1'b0), .ZERO_REG(1'b0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .WE(we[1]), .WA(wa[1]), .WD(wd[1]), .RE(re[1]),
        .RA(ra[1]), .RB(rb[1]), .RDoutA(rda[1]), .RDoutB(rdb[1]), .RValid(rv[1]));

    param_regfile_2r1w #(.WIDTH(4), .DEPTH(8), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_zero (
        .clk(clk), .rst_n(rst_n), .WE(we[2]), .WA(wa[2]), .WD(wd[2]), .RE(re[2]),
        .RA(ra[2]), .RB(rb[2]), .RDoutA(rda[2]), .RDoutB(rdb[2]), .RValid(rv[2]));

    param_regfile_2r1w #(.WIDTH(4), .DEPTH(6), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_d6 (
        .clk(clk), .rst_n(rst_n), .WE(we[3]), .WA(wa[3]), .WD(wd[3]), .RE(re[3]),
        .RA(ra[3]), .RB(rb[3]), .RDoutA(rda[3]), .RDoutB(rdb[3]), .RValid(rv[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idleAll();
        for (int k = 0; k < 4; k++) begin
            we[k] = 1'b0; wa[k] = '0; wd[k] = '0;
            re[k] = 1'b0; ra[k] = '0; rb[k] = '0;
        end
    endtask

    // Drives one instance for the coming edge; a read also queues its expected result.
    task automatic applyStimulus(input int k, input logic w, input logic [2:0] a_wa,
                                 input logic [3:0] a_wd, input logic r, input logic [2:0] a_ra,
                                 input logic [2:0] a_rb, input logic [3:0] ea, input logic [3:0] eb);
        exp_t e;
        we[k] = w; wa[k] = a_wa; wd[k] = a_wd;
        re[k] = r; ra[k] = a_ra; rb[k] = a_rb;
        if (r) begin
            e.a = ea;
            e.b = eb;
            expq[k].push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idleAll();
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst_n && rv[k]) begin
                if (expq[k].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_rvalid inst%0d: got RValid=1, expected no read", k);
                end else begin
                    exp_t e;
                    e = expq[k].pop_front();
                    checkOutput($sformatf("inst%0d_RDoutA", k), {4'b0, rda[k]}, {4'b0, e.a});
                    checkOutput($sformatf("inst%0d_RDoutB", k), {4'b0, rdb[k]}, {4'b0, e.b});
                end
            end
        end
    end

    initial begin
        int expA [5];
        int expB [5];
        expA = '{10, 9, 8, 7, 6};
        expB = '{3, 4, 5, 6, 7};
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        idleAll();

        #12;
        checkOutput("reset_RDoutA", {4'b0, rda[0]}, 8'd0);
        checkOutput("reset_RDoutB", {4'b0, rdb[0]}, 8'd0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("reset_RValid_inst%0d", k), {7'b0, rv[k]}, 8'd0);
        end
        rst_n = 1'b1;

        // Load regs with 10 down to 3 on every instance (DEPTH=6 instance only 0..5).
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1'b1, 3'(i), 4'(10 - i), 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
            applyStimulus(1, 1'b1, 3'(i), 4'(10 - i), 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
            applyStimulus(2, 1'b1, 3'(i), 4'(10 - i), 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
            if (i < 6) applyStimulus(3, 1'b1, 3'(i), 4'(10 - i), 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
            step();
        end

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1'b0, 3'd0, 4'd0, 1'b1, 3'(i), 3'(7 - i), 4'(expA[i]), 4'(expB[i]));
            step();
        end

        // Same-address write and read: bypass vs. pre-write value.
        applyStimulus(0, 1'b1, 3'd2, 4'd13, 1'b1, 3'd2, 3'd5, 4'd13, 4'd5);
        applyStimulus(1, 1'b1, 3'd2, 4'd13, 1'b1, 3'd2, 3'd5, 4'd8, 4'd5);
        step();
        applyStimulus(0, 1'b0, 3'd0, 4'd0, 1'b1, 3'd2, 3'd2, 4'd13, 4'd13);
        applyStimulus(1, 1'b0, 3'd0, 4'd0, 1'b1, 3'd2, 3'd2, 4'd13, 4'd13);
        step();

        // Zero register ignores writes and wins over bypass.
        applyStimulus(2, 1'b1, 3'd0, 4'd15, 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
        step();
        applyStimulus(2, 1'b0, 3'd0, 4'd0, 1'b1, 3'd0, 3'd1, 4'd0, 4'd9);
        step();
        applyStimulus(2, 1'b1, 3'd1, 4'd15, 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
        step();
        applyStimulus(2, 1'b0, 3'd0, 4'd0, 1'b1, 3'd1, 3'd0, 4'd15, 4'd0);
        step();
        applyStimulus(2, 1'b1, 3'd0, 4'd7, 1'b1, 3'd0, 3'd3, 4'd0, 4'd7);
        step();

        // DEPTH=6: out-of-range write ignored, out-of-range reads return 0.
        applyStimulus(3, 1'b1, 3'd7, 4'd9, 1'b0, 3'd0, 3'd0, 4'd0, 4'd0);
        step();
        applyStimulus(3, 1'b0, 3'd0, 4'd0, 1'b1, 3'd7, 3'd6, 4'd0, 4'd0);
        step();
        applyStimulus(3, 1'b1, 3'd6, 4'd9, 1'b1, 3'd6, 3'd7, 4'd0, 4'd0);
        step();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3, 1'b0, 3'd0, 4'd0, 1'b1, 3'(i), 3'(5 - i), 4'(10 - i), 4'(5 + i));
            step();
        end

        // RE pattern 1,0,0,1 with mem[3] rewritten while idle.
        applyStimulus(0, 1'b0, 3'd0, 4'd0, 1'b1, 3'd3, 3'd0, 4'd7, 4'd10);
        step();
        applyStimulus(0, 1'b1, 3'd3, 4'd1, 1'b0, 3'd3, 3'd0, 4'd0, 4'd0);
        step();
        checkOutput("idle1_RValid", {7'b0, rv[0]}, 8'd0);
        checkOutput("idle1_RDoutA_hold", {4'b0, rda[0]}, 8'd7);
        applyStimulus(0, 1'b1, 3'd3, 4'd2, 1'b0, 3'd3, 3'd0, 4'd0, 4'd0);
        step();
        checkOutput("idle2_RValid", {7'b0, rv[0]}, 8'd0);
        checkOutput("idle2_RDoutA_hold", {4'b0, rda[0]}, 8'd7);
        checkOutput("idle2_RDoutB_hold", {4'b0, rdb[0]}, 8'd10);
        applyStimulus(0, 1'b0, 3'd0, 4'd0, 1'b1, 3'd3, 3'd3, 4'd2, 4'd2);
        step();

        // Mid-cycle asynchronous reset after a read has loaded nonzero data.
        applyStimulus(0, 1'b1, 3'd4, 4'd11, 1'b1, 3'd4, 3'd6, 4'd11, 4'd4);
        step();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_RDoutA", {4'b0, rda[0]}, 8'd0);
        checkOutput("async_reset_RDoutB", {4'b0, rdb[0]}, 8'd0);
        checkOutput("async_reset_RValid", {7'b0, rv[0]}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1'b0, 3'd0, 4'd0, 1'b1, 3'(i), 3'(7 - i), 4'd0, 4'd0);
            step();
        end

        repeat (4) step();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("inst%0d_pending_reads", k), 8'(expq[k].size()), 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/param_regfile_2r1w.md
Name: param_regfile_2r1w

Overview:
Parametrised register file with one write port and two registered read ports. It generalises the 8:1 read-select mux into a full storage block with configurable data width, depth, write-to-read bypass and an optional hard-wired zero register. It sits in the register-file datapath and feeds operand buses A and B.

Parameters:
WIDTH, 4, data width of each register in bits
DEPTH, 8, number of registers; any value from 2 to 256
AW, $clog2(DEPTH), address width; derived from DEPTH, never overridden
BYPASS, 1, 1 = same-cycle write data forwarded to a read of the same address; 0 = read returns the pre-write value
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
WE  in  1  write enable
WA  in  AW  write address
WD  in  WIDTH  write data
RE  in  1  read enable; applies to both read ports
RA  in  AW  read address, port A
RB  in  AW  read address, port B
RDoutA  out  WIDTH  registered read data, port A
RDoutB  out  WIDTH  registered read data, port B
RValid  out  1  high for one cycle when RDoutA/RDoutB carry the data for a sampled RE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset, while rst_n=0:
  - All DEPTH registers are 0.
  - RDoutA=0, RDoutB=0, RValid=0.
  - Reset takes effect immediately, without waiting for a clock edge, including in the middle of a read or write.
  - The first rising edge after rst_n deasserts is a normal operating edge.
- Write:
  - At a rising edge with WE=1 and WA<DEPTH, mem[WA] <= WD.
  - Ignored when WA>=DEPTH (non-power-of-2 DEPTH).
  - Ignored when ZERO_REG=1 and WA=0.
- Read (1-cycle latency):
  - At a rising edge with RE=1, RDoutA and RDoutB load the selected values and RValid <= 1.
  - At a rising edge with RE=0, RDoutA and RDoutB hold their values and RValid <= 0.
  - Back-to-back RE gives a new result every cycle.
- Selected value for port X (A or B), in priority order:
  1. Address >= DEPTH -> 0.
  2. ZERO_REG=1 and address = 0 -> 0.
  3. BYPASS=1, WE=1 and WA = address (write legal) -> WD.
  4. Otherwise -> mem[address] as it stood before the edge.
- Simultaneous events:
  - RA=RB is legal; both ports return the same value.
  - A write and a read to different addresses in the same cycle are independent.
  - With BYPASS=0, a same-address read returns the old value; the new value is visible from the next read.
- No combinational path from any input to any output; all outputs come straight from flops.
- Storage: DEPTH x WIDTH flops. The read mux is a parametrised DEPTH:1 select, no tri-states.

Test Plan:
1. Reset, then write regs 0..7 with 10,9,8,7,6,5,4,3. Then with RE=1 step RA=0..4 and RB=7..3 -> one cycle after each edge, RDoutA=10,9,8,7,6; RDoutB=3,4,5,6,7; RValid=1 each cycle.
2. BYPASS=1: hold mem[2]=8, then in one cycle drive WE=1, WA=2, WD=13, RE=1, RA=2 -> RDoutA=13 next cycle. Repeat with BYPASS=0 -> RDoutA=8 first, then 13 on the following read.
3. ZERO_REG=1: write WA=0, WD=15, then read RA=0 -> RDoutA=0. Write WA=1, WD=15, then read RA=1 -> RDoutA=15.
4. DEPTH=6: write WA=7, WD=9, then read RA=7 and RB=6 -> both read 0, and regs 0..5 are unchanged.
5. RE sequence 1,0,0,1 with RA fixed at 3 and mem[3] changed during the idle cycles -> RValid=1,0,0,1. RDoutA holds its value during the idle cycles and updates on the final read.
6. Assert rst_n=0 mid-cycle, between clock edges, after writes -> RDoutA, RDoutB and RValid go to 0 immediately. After release, reading every address returns 0.
